dspl_msg_sched: RTL and testbench
=================================

Name: dspl_msg_sched

Overview:
- Time-shares the 8-digit multiplexed display driver between 3 requesters (e.g. game FSM, error monitor, score counter).
- Each requester offers a full 8-digit message. The block grants requesters round-robin, latches the winning message, and drives the driver's d1..d8 inputs for a fixed hold time.
- After the hold time it signals completion to that requester.
- Sits directly upstream of the display driver; its outputs connect 1:1 to the driver's digit inputs.

Parameters:
- MS_COUNT, 100000: clock cycles per 1 ms tick; must be >= 2.
- HOLD_MS, 2000: ms a granted message stays on the display; must be >= 1.
- BLINK_MS, 250: blink half-period in ms; used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  3  req[i] high = requester i wants the display; level, held until gnt[i]
- msg0  in  48  requester 0 message; bits [6k+5:6k] = digit k+1; bit 5 of each digit = enable, bits 4:0 = code
- msg1  in  48  requester 1 message, same format
- msg2  in  48  requester 2 message, same format
- gnt  out  3  one-cycle pulse; message i latched on this cycle
- done  out  3  one-cycle pulse; requester i's hold time has expired
- busy  out  1  high while a message is shown
- d1..d8  out  6 each  digit words to the display driver
- blink  in  3  blink[i] latched with msg i at grant; present only with DSPL_BLINK_EN

Behaviour:
- Reset values:
  - All outputs 0: d1..d8 = 6'b000000 (all digits disabled), gnt = 0, done = 0, busy = 0.
  - State = IDLE, round-robin pointer rr = 0, prescaler = 0, ms counter = 0.
- States: IDLE, SHOW. All outputs are registered.
- IDLE:
  - d1..d8 = 0, busy = 0.
  - If any req bit is high at a clock edge, pick the first requester at or after rr, scanning rr, rr+1, rr+2 mod 3.
  - On that edge: latch its msg (and its blink bit), assert gnt[i] for exactly that cycle, load d1..d8 from the latched message, busy <= 1, clear prescaler and ms counter, go to SHOW.
- Latency: req sampled high at edge N -> gnt, busy and d valid after edge N (cycle N+1).
- SHOW:
  - Prescaler counts 0..MS_COUNT-1 and wraps; the wrap increments the ms counter.
  - d1..d8 hold the latched message and ignore changes on msg/req.
  - The display time is exactly HOLD_MS*MS_COUNT cycles: from the cycle gnt is high to the cycle done is high.
  - On the edge where the ms counter would reach HOLD_MS:
    - done[i] <= 1 for one cycle, d1..d8 <= 0, busy <= 0.
    - rr <= (i+1) mod 3, go to IDLE.
- Back-to-back: the next grant can occur no earlier than the cycle after done; d is blank for at least one cycle between messages.
- Simultaneous requests: resolved strictly by rr. A requester just served has lowest priority next, so there is no starvation.
- Requester drops req before its grant: it is not served; no gnt, no done.
- Requester drops req during SHOW: no effect; its message runs to completion and done still pulses.
- Requester keeps req high through done: treated as a new request, served after the others per rr.
- Reset asserted mid-SHOW: immediate return to the reset values; no done pulse is generated.
- gnt and done never have more than one bit set at a time, and are never high in the same cycle.

Optional Feature:
- Macro: DSPL_BLINK_EN.
- Defined:
  - The blink port exists.
  - If the latched blink bit is 1, during SHOW the bit 5 of every digit is ANDed with a phase flag.
  - The phase flag starts at 1 at grant and toggles every BLINK_MS ms ticks.
  - Codes (bits 4:0) are unchanged.
  - Hold time and done timing are unaffected.
- Not defined: no blink port, no blink logic; the message is shown steady.

Test Plan (MS_COUNT=4, HOLD_MS=3, BLINK_MS=1):
- Reset check: assert reset mid-operation -> d1..d8 = 0, gnt = 0, done = 0, busy = 0 immediately.
- Single request: req = 3'b001, msg0 = {8{6'b100101}} -> gnt = 001 one cycle after req sampled.
  - d1..d8 = 6'h25 for 12 cycles, then done = 001, d = 0, busy = 0.
- Simultaneous requests: req = 3'b111 held -> grant order 0, 1, 2, 0 with rr advancing.
  - Each message shows for 12 cycles; 1 blank cycle between messages.
- Late request / drop during SHOW: req1 rises during requester 0's SHOW and req0 drops during SHOW.
  - -> requester 0 still gets done; gnt = 010 on the cycle after done.
- Reset mid-SHOW: reset asserted at cycle 5 of the hold -> all outputs 0, no done.
  - After release, req = 3'b100 -> requester 2 is granted (rr = 0 scan order skips 0 and 1).
- DSPL_BLINK_EN, blink0 = 1: bit 5 of all digits toggles every 4 cycles (1 1 1 1 0 0 0 0 1 1 1 1) -> done still at cycle 12.

Source files
------------

// File: rtl/dspl_msg_sched.sv
// Round-robin scheduler that time-shares the 8-digit display driver among 3 requesters.
// Defining DSPL_BLINK_EN adds a per-grant blink option (blink port and phase logic).

module dspl_msg_sched #(
    parameter int unsigned MS_COUNT = 100000,
    parameter int unsigned HOLD_MS  = 2000,
    parameter int unsigned BLINK_MS = 250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [47:0] msg0,
    input  logic [47:0] msg1,
    input  logic [47:0] msg2,
`ifdef DSPL_BLINK_EN
    input  logic [2:0]  blink,
`endif
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        busy,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4,
    output logic [5:0]  d5,
    output logic [5:0]  d6,
    output logic [5:0]  d7,
    output logic [5:0]  d8
);

    if (MS_COUNT < 2) begin : g_bad_ms_count
        $error("MS_COUNT must be at least 2");
    end
    if (HOLD_MS < 1) begin : g_bad_hold_ms
        $error("HOLD_MS must be at least 1");
    end
    if (BLINK_MS < 1) begin : g_bad_blink_ms
        $error("BLINK_MS must be at least 1");
    end

    localparam int unsigned PRE_W = $clog2(MS_COUNT);
    localparam int unsigned MS_W  = $clog2(HOLD_MS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_COUNT - 1);
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(HOLD_MS - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic [1:0]        sel_q, sel_d;
    logic [47:0]       msg_q, msg_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        done_q, done_d;
    logic              busy_q, busy_d;
    logic [47:0]       d_q, d_d;

`ifdef DSPL_BLINK_EN
    localparam int unsigned BLK_W = $clog2(BLINK_MS + 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_MS - 1);

    logic              blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [BLK_W-1:0]  bcnt_q, bcnt_d;
    logic              pick_blink;

    // Gates the enable bit of every digit; codes pass through untouched.
    function automatic logic [47:0] blink_mask(input logic [47:0] m, input logic on);
        logic [47:0] r;
        r = m;
        for (int k = 0; k < 8; k++) begin
            r[6*k+5] = m[6*k+5] & on;
        end
        return r;
    endfunction
`endif

    // Round-robin pick: rotate req so bit 0 is the requester at rr, take the first set bit.
    logic [2:0]  req_rot;
    logic [1:0]  pick_off;
    logic [2:0]  pick_sum;
    logic [1:0]  pick_idx;
    logic [47:0] pick_msg;
    logic        pick_valid;

    always_comb begin
        case (rr_q)
            2'd1:    req_rot = {req[0], req[2], req[1]};
            2'd2:    req_rot = {req[1], req[0], req[2]};
            default: req_rot = req;
        endcase

        if (req_rot[0]) begin
            pick_off = 2'd0;
        end else if (req_rot[1]) begin
            pick_off = 2'd1;
        end else begin
            pick_off = 2'd2;
        end

        pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
        pick_idx = (pick_sum >= 3'd3) ? (pick_sum[1:0] - 2'd3) : pick_sum[1:0];

        case (pick_idx)
            2'd1:    pick_msg = msg1;
            2'd2:    pick_msg = msg2;
            default: pick_msg = msg0;
        endcase

`ifdef DSPL_BLINK_EN
        case (pick_idx)
            2'd1:    pick_blink = blink[1];
            2'd2:    pick_blink = blink[2];
            default: pick_blink = blink[0];
        endcase
`endif
    end

    assign pick_valid = |req;

    always_comb begin
        // NOTE: every next-state value holds by default first, so no path can infer a latch.
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        msg_d   = msg_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        gnt_d   = 3'b000;
        done_d  = 3'b000;
        busy_d  = busy_q;
        d_d     = d_q;
`ifdef DSPL_BLINK_EN
        blink_d = blink_q;
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                d_d    = '0;
                busy_d = 1'b0;
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    msg_d   = pick_msg;
                    gnt_d   = 3'b001 << pick_idx;
                    busy_d  = 1'b1;
                    pre_d   = '0;
                    ms_d    = '0;
                    d_d     = pick_msg;
                    state_d = SHOW;
`ifdef DSPL_BLINK_EN
                    blink_d = pick_blink;
                    phase_d = 1'b1;
                    bcnt_d  = '0;
`endif
                end
            end

            SHOW: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (ms_q == MS_LAST) begin
                        done_d  = 3'b001 << sel_q;
                        busy_d  = 1'b0;
                        rr_d    = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                        state_d = IDLE;
                    end else begin
                        ms_d = ms_q + 1'b1;
`ifdef DSPL_BLINK_EN
                        if (bcnt_q == BLK_LAST) begin
                            bcnt_d  = '0;
                            phase_d = ~phase_q;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
`endif
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end

                if (state_d == IDLE) begin
                    d_d = '0;
                end else begin
`ifdef DSPL_BLINK_EN
                    d_d = blink_mask(msg_q, ~blink_q | phase_d);
`else
                    d_d = msg_q;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 2'd0;
            sel_q   <= 2'd0;
            msg_q   <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            gnt_q   <= 3'b000;
            done_q  <= 3'b000;
            busy_q  <= 1'b0;
            d_q     <= '0;
`ifdef DSPL_BLINK_EN
            blink_q <= 1'b0;
            phase_q <= 1'b0;
            bcnt_q  <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment only; all next values come from the comb block.
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            msg_q   <= msg_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            d_q     <= d_d;
`ifdef DSPL_BLINK_EN
            blink_q <= blink_d;
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign d1   = d_q[5:0];
    assign d2   = d_q[11:6];
    assign d3   = d_q[17:12];
    assign d4   = d_q[23:18];
    assign d5   = d_q[29:24];
    assign d6   = d_q[35:30];
    assign d7   = d_q[41:36];
    assign d8   = d_q[47:42];

endmodule

// File: tb/tb_dspl_msg_sched.sv
// Bench for dspl_msg_sched: transaction-level model compared every cycle, plus directed
// literal checks for reset, single grant, round-robin order, late request and mid-hold reset.

module tb_dspl_msg_sched;

    localparam int MS_COUNT = 4;
    localparam int HOLD_MS  = 3;
    localparam int BLINK_MS = 1;
    localparam int HOLD_CYC = MS_COUNT * HOLD_MS;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] msg0, msg1, msg2;
    logic [2:0]  blink;
    logic [2:0]  gnt, done;
    logic        busy;
    logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
    logic [47:0] d_all;

    assign d_all = {d8, d7, d6, d5, d4, d3, d2, d1};

    dspl_msg_sched #(
        .MS_COUNT (MS_COUNT),
        .HOLD_MS  (HOLD_MS),
        .BLINK_MS (BLINK_MS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .msg0  (msg0),
        .msg1  (msg1),
        .msg2  (msg2),
`ifdef DSPL_BLINK_EN
        .blink (blink),
`endif
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .d4    (d4),
        .d5    (d5),
        .d6    (d6),
        .d7    (d7),
        .d8    (d8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) cyc++;

    // Reference model: a message is visible for HOLD_CYC cycles counted from its grant.
    bit          m_show  = 1'b0;
    int          m_rr    = 0;
    int          m_sel   = 0;
    int          m_k     = 0;
    logic [47:0] m_msg   = '0;
    logic        m_blink = 1'b0;
    logic [2:0]  e_gnt   = '0;
    logic [2:0]  e_done  = '0;
    logic        e_busy  = 1'b0;
    logic [47:0] e_d     = '0;

    function automatic logic [47:0] view(input logic [47:0] m, input logic b, input int k);
        logic [47:0] r;
        r = m;
        if (b && ((k / (BLINK_MS * MS_COUNT)) % 2 == 1)) begin
            for (int j = 0; j < 8; j++) r[6*j+5] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [47:0] msg_of(input int i);
        return (i == 0) ? msg0 : (i == 1) ? msg1 : msg2;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_show = 1'b0; m_rr = 0; m_sel = 0; m_k = 0; m_msg = '0; m_blink = 1'b0;
            e_gnt = '0; e_done = '0; e_busy = 1'b0; e_d = '0;
        end else begin
            e_gnt  = '0;
            e_done = '0;
            if (m_show) begin
                m_k++;
                if (m_k == HOLD_CYC) begin
                    e_done = 3'(1 << m_sel);
                    e_busy = 1'b0;
                    e_d    = '0;
                    m_show = 1'b0;
                    m_rr   = (m_sel + 1) % 3;
                end else begin
                    e_d = view(m_msg, m_blink, m_k);
                end
            end else begin
                bit found;
                found  = 1'b0;
                e_d    = '0;
                e_busy = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    int idx;
                    idx = (m_rr + j) % 3;
                    if (!found && req[idx]) begin
                        found  = 1'b1;
                        m_sel  = idx;
                        m_msg  = msg_of(idx);
`ifdef DSPL_BLINK_EN
                        m_blink = blink[idx];
`else
                        m_blink = 1'b0;
`endif
                        m_k    = 0;
                        m_show = 1'b1;
                        e_gnt  = 3'(1 << idx);
                        e_busy = 1'b1;
                        e_d    = view(m_msg, m_blink, 0);
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("gnt", 64'(gnt), 64'(e_gnt));
            check("done", 64'(done), 64'(e_done));
            check("busy", 64'(busy), 64'(e_busy));
            check("digits", 64'(d_all), 64'(e_d));
        end
    end

    int q_gi[$];
    int q_gc[$];
    always @(negedge clock) begin
        if (gnt != 3'b000) begin
            q_gi.push_back(gnt[0] ? 0 : (gnt[1] ? 1 : 2));
            q_gc.push_back(cyc);
        end
    end

    initial begin
        int base;
        int ndone;
        int exp_order[4];
        logic [11:0] pat;
        exp_order = '{0, 1, 2, 0};
        pat = 12'b111100001111;

        reset = 1'b1; req = '0; blink = '0;
        msg0 = '0; msg1 = '0; msg2 = '0;
        step();
        cmp_en = 1'b1;
        step();
        @(negedge clock);
        check("reset_gnt", 64'(gnt), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_digits", 64'(d_all), 64'd0);

        // Simultaneous requests held high: order 0,1,2,0 spaced by hold + 1 blank cycle.
        step();
        reset = 1'b0;
        msg0 = 48'({$urandom(), $urandom()});
        msg1 = 48'({$urandom(), $urandom()});
        msg2 = 48'({$urandom(), $urandom()});
        base = q_gi.size();
        req = 3'b111;
        for (int i = 0; i < 100 && q_gi.size() < base + 4; i++) begin
            step();
            @(negedge clock);
            #1;
        end
        req = 3'b000;
        if (q_gi.size() < base + 4) begin
            check("rr_grant_timeout", 64'(q_gi.size() - base), 64'd4);
        end else begin
            for (int i = 0; i < 4; i++) check("rr_order", 64'(q_gi[base+i]), 64'(exp_order[i]));
            for (int i = 0; i < 3; i++) check("rr_spacing", 64'(q_gc[base+i+1] - q_gc[base+i]), 64'(HOLD_CYC + 1));
        end
        repeat (HOLD_CYC + 1) step();

        // Single request from 0 (rr now at 1, scan wraps to 0).
        msg0 = {8{6'b100101}};
        req = 3'b001;
        step();
        req = 3'b000;
        @(negedge clock);
        check("single_gnt", 64'(gnt), 64'b001);
        check("single_d1", 64'(d1), 64'h25);
        check("single_d8", 64'(d8), 64'h25);
        check("single_busy", 64'(busy), 64'd1);
        repeat (HOLD_CYC - 1) step();
        @(negedge clock);
        check("single_last_d1", 64'(d1), 64'h25);
        check("single_last_done", 64'(done), 64'd0);
        step();
        @(negedge clock);
        check("single_done", 64'(done), 64'b001);
        check("single_done_d", 64'(d_all), 64'd0);
        check("single_done_busy", 64'(busy), 64'd0);

        // Late request from 1 while 0 shows; 0 drops its req mid-hold.
        msg1 = 48'({$urandom(), $urandom()});
        req = 3'b001;
        step();
        @(negedge clock);
        check("late_gnt0", 64'(gnt), 64'b001);
        repeat (3) step();
        req = 3'b010;
        repeat (HOLD_CYC - 3) step();
        @(negedge clock);
        check("late_done0", 64'(done), 64'b001);
        check("late_no_gnt", 64'(gnt), 64'd0);
        step();
        @(negedge clock);
        check("late_gnt1", 64'(gnt), 64'b010);
        check("late_msg1", 64'(d_all), 64'(msg1));
        req = 3'b000;

        // Reset five cycles into requester 1's hold.
        repeat (5) step();
        reset = 1'b1;
        #2;
        check("midreset_gnt", 64'(gnt), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_digits", 64'(d_all), 64'd0);
        step();
        step();
        reset = 1'b0;
        ndone = 0;
        repeat (HOLD_CYC + 3) begin
            step();
            @(negedge clock);
            if (done != 3'b000) ndone++;
        end
        check("midreset_no_done", 64'(ndone), 64'd0);
        req = 3'b100;
        step();
        @(negedge clock);
        check("after_reset_gnt2", 64'(gnt), 64'b100);
        req = 3'b000;
        repeat (HOLD_CYC + 1) step();

`ifdef DSPL_BLINK_EN
        blink = 3'b001;
        msg0 = {8{6'b100101}};
        req = 3'b001;
        step();
        req = 3'b000;
        for (int k = 0; k < HOLD_CYC; k++) begin
            @(negedge clock);
            check("blink_en_bit", 64'(d1[5]), 64'(pat[11-k]));
            check("blink_code", 64'(d1[4:0]), 64'h05);
            step();
        end
        @(negedge clock);
        check("blink_done", 64'(done), 64'b001);
        blink = 3'b000;
        step();
`endif

        // Random traffic: requests, messages and blink bits change every cycle; rare resets.
        for (int i = 0; i < 600; i++) begin
            req   = 3'($urandom());
            msg0  = 48'({$urandom(), $urandom()});
            msg1  = 48'({$urandom(), $urandom()});
            msg2  = 48'({$urandom(), $urandom()});
            blink = 3'($urandom());
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 1'b0;
        req = 3'b000;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
